// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port plus the
// registered instruction handshake towards the decoder.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    // Fetch unit side: issues memory requests, presents instructions
    modport master (
        output imem_req, imem_addr, instr_out, instr_pc, instr_valid,
        input  imem_rdata, imem_ack, instr_ready
    );

    // Environment side: memory responder and decoder
    modport slave (
        input  imem_req, imem_addr, instr_out, instr_pc, instr_valid,
        output imem_rdata, imem_ack, instr_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads over req/ack,
// registers each fetched word for the decoder (valid/ready), and handles
// redirect and halt. A redirect that lands while a read is outstanding
// parks in DRAIN until the read completes, since the address must stay
// stable for the whole request.
module instruction_fetch_unit #(
    parameter int unsigned       ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    instruction_fetch_unit_if.master bus,
    output logic                     halted,
    output logic [CNT_W-1:0]         fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [ADDR_W-1:0] target_q,      target_d;
    logic              halt_pend_q,   halt_pend_d;
    logic [31:0]       instr_out_q,   instr_out_d;
    logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            target_q      <= RESET_PC;
            halt_pend_q   <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            halt_pend_q   <= halt_pend_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic; priority within each state is halt > redirect > ack/transfer
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        halt_pend_d   = halt_pend_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (start) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (halt) begin
                    if (bus.imem_ack) begin
                        instr_valid_d = 1'b0;
                        state_d       = S_HALTED;
                    end else begin
                        halt_pend_d = 1'b1;
                        state_d     = S_DRAIN;
                    end
                end else if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    if (bus.imem_ack) begin
                        // Returned word belongs to the old path: drop it and refetch
                        pc_d    = redirect_pc;
                        state_d = S_REQ;
                    end else begin
                        target_d    = redirect_pc;
                        halt_pend_d = 1'b0;
                        state_d     = S_DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    instr_out_d   = bus.imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 1'b1;
                    state_d       = S_HOLD;
                end
            end

            S_HOLD: begin
                if (halt) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_HALTED;
                end else if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end else if (instr_valid_q && bus.instr_ready) begin
                    fetch_count_d = fetch_count_q + 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end

            S_DRAIN: begin
                if (halt) begin
                    halt_pend_d = 1'b1;
                end
                if (redirect_valid) begin
                    target_d = redirect_pc;
                end
                if (bus.imem_ack) begin
                    // Latest redirect wins, including one arriving with the ack
                    pc_d        = redirect_valid ? redirect_pc : target_q;
                    halt_pend_d = 1'b0;
                    state_d     = (halt_pend_q || halt) ? S_HALTED : S_REQ;
                end
            end

            S_HALTED: begin
                instr_valid_d = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign halted          = (state_q == S_HALTED);
    assign fetch_count     = fetch_count_q;

endmodule
